// File: rtl/mpadd_seq_if.sv
// Operand/result handshakes and the external 32-bit adder connection for mpadd_seq.
// The slave modport is the adder engine's view; master is the requester/adder side.
interface mpadd_seq_if #(
    parameter int NWORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [32*NWORDS-1:0]  op_a;
    logic [32*NWORDS-1:0]  op_b;
    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic [31:0]           add_s;
    logic                  add_c32;
    logic [32*NWORDS-1:0]  res;
    logic                  res_cout;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_valid, op_a, op_b, add_s, add_c32, out_ready,
        output in_ready, add_a, add_b, res, res_cout, out_valid
    );

    modport master (
        output in_valid, op_a, op_b, add_s, add_c32, out_ready,
        input  in_ready, add_a, add_b, res, res_cout, out_valid
    );
endinterface

// File: rtl/mpadd_seq.sv
// Multi-word adder that time-shares one external 32-bit adder (no carry-in) word by word.
// Define MPADD_SKIP_INC_EN to skip the carry-increment cycle for words entered with no carry.
module mpadd_seq #(
    parameter int NWORDS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    mpadd_seq_if.slave bus
);
    localparam int             IW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        INC,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      cy_q, cy_d;
    logic                      c1_q, c1_d;
    logic [31:0]               tmp_q, tmp_d;
    logic [NWORDS-1:0][31:0]   opA_q, opA_d;
    logic [NWORDS-1:0][31:0]   opB_q, opB_d;
    logic [NWORDS-1:0][31:0]   res_q, res_d;
    logic                      resCout_q, resCout_d;
    logic [31:0]               addA, addB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cy_q      <= 1'b0;
            c1_q      <= 1'b0;
            tmp_q     <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            res_q     <= '0;
            resCout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cy_q      <= cy_d;
            c1_q      <= c1_d;
            tmp_q     <= tmp_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            res_q     <= res_d;
            resCout_q <= resCout_d;
        end
    end

    // SUM adds the raw word pair; INC folds the previous carry in, since the adder has no carry-in.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cy_d      = cy_q;
        c1_d      = c1_q;
        tmp_d     = tmp_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        res_d     = res_q;
        resCout_d = resCout_q;
        addA      = '0;
        addB      = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d   = bus.op_a;
                    opB_d   = bus.op_b;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    state_d = SUM;
                end
            end
            SUM: begin
                addA = opA_q[idx_q];
                addB = opB_q[idx_q];
`ifdef MPADD_SKIP_INC_EN
                if (!cy_q) begin
                    res_d[idx_q] = bus.add_s;
                    cy_d         = bus.add_c32;
                    if (idx_q == LAST) begin
                        resCout_d = bus.add_c32;
                        state_d   = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SUM;
                    end
                end else begin
                    tmp_d   = bus.add_s;
                    c1_d    = bus.add_c32;
                    state_d = INC;
                end
`else
                tmp_d   = bus.add_s;
                c1_d    = bus.add_c32;
                state_d = INC;
`endif
            end
            INC: begin
                // The two carries are mutually exclusive, so OR is the true carry-out.
                addA         = tmp_q;
                addB         = {31'b0, cy_q};
                res_d[idx_q] = bus.add_s;
                cy_d         = c1_q | bus.add_c32;
                if (idx_q == LAST) begin
                    resCout_d = c1_q | bus.add_c32;
                    state_d   = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SUM;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so nothing is offered acceptance while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.add_a     = addA;
    assign bus.add_b     = addB;
    assign bus.res       = res_q;
    assign bus.res_cout  = resCout_q;
endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq: plays the requester and the external 32-bit adder.
module tb_mpadd_seq;
    localparam int NW = 4;
    localparam int W  = 32 * NW;
`ifdef MPADD_SKIP_INC_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    mpadd_seq_if #(.NWORDS(NW)) bus ();

    mpadd_seq #(.NWORDS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External adder: combinational, no carry-in.
    assign {bus.add_c32, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    task automatic checkOutput(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expRes, input logic expCout,
                                 input int expLat, input int holdCycles);
        int lat;
        @(negedge clk);
        checkOutput("idle_in_ready", bus.in_ready, 1);
        checkOutput("idle_add_a", bus.add_a, 0);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = ~a;
        bus.op_b     = ~b ^ W'('h5a);
        checkOutput("sum0_add_a", bus.add_a, a[31:0]);
        checkOutput("sum0_add_b", bus.add_b, b[31:0]);
        checkOutput("busy_in_ready", bus.in_ready, 0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, expLat);
        checkOutput("res", bus.res, expRes);
        checkOutput("res_cout", bus.res_cout, expCout);
        checkOutput("done_in_ready", bus.in_ready, 0);
        checkOutput("done_add_a", bus.add_a, 0);
        checkOutput("done_add_b", bus.add_b, 0);
        if (holdCycles > 0) begin
            bus.in_valid = 1'b1;
            bus.op_a     = '1;
            bus.op_b     = W'('h3);
            for (int i = 0; i < holdCycles; i++) begin
                @(posedge clk);
                #1;
                checkOutput("hold_res", bus.res, expRes);
                checkOutput("hold_cout", bus.res_cout, expCout);
                checkOutput("hold_valid", bus.out_valid, 1);
                checkOutput("hold_in_ready", bus.in_ready, 0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("consumed_valid", bus.out_valid, 0);
        checkOutput("consumed_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic resetMidOp();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
        b = 128'h11111111_11111111_11111111_11111111;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (SKIP ? 1 : 2) @(posedge clk);
        #1;
        checkOutput("sum1_add_a", bus.add_a, a[63:32]);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_res", bus.res, 0);
        checkOutput("rst_cout", bus.res_cout, 0);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_add_a", bus.add_a, 0);
        checkOutput("rst_add_b", bus.add_b, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_hold_valid", bus.out_valid, 0);
        end
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        rst_n         = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_valid", bus.out_valid, 0);
        checkOutput("reset_res", bus.res, 0);
        checkOutput("reset_cout", bus.res_cout, 0);
        checkOutput("reset_add_a", bus.add_a, 0);
        checkOutput("reset_add_b", bus.add_b, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", bus.in_ready, 1);

        applyStimulus(128'h1, 128'h2, 128'h3, 1'b0, SKIP ? 4 : 8, 0);
        applyStimulus('1, 128'h1, 128'h0, 1'b1, SKIP ? 7 : 8, 0);
        applyStimulus(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1,
                      128'h00000001_00000000_00000000_00000000, 1'b0, SKIP ? 7 : 8, 0);
        applyStimulus(128'h80000000_00000000_00000000_00000000,
                      128'h80000000_00000000_00000000_00000000,
                      128'h0, 1'b1, SKIP ? 4 : 8, 5);
        applyStimulus(128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
                      128'h11111111_11111111_11111111_11111111,
                      128'h23456789_ABCDF001_20FEDCBA_98765432, 1'b0, SKIP ? 4 : 8, 0);
        applyStimulus(128'hFFFFFFFF_00000000_FFFFFFFF_00000001,
                      128'h00000001_00000000_00000001_FFFFFFFF,
                      128'h00000000_00000001_00000001_00000000, 1'b1, SKIP ? 6 : 8, 0);

        resetMidOp();
        applyStimulus(128'h1, 128'h2, 128'h3, 1'b0, SKIP ? 4 : 8, 0);
        applyStimulus('1, 128'h1, 128'h0, 1'b1, SKIP ? 7 : 8, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
